// File: rtl/gray_mem_arbiter.sv
// Two-requester read arbiter for the 64x8 gray image memory.
// Round-robin with bounded burst lock; a tag pipe routes each returned byte to its requester.
module gray_mem_arbiter #(
  parameter int MAX_LOCK = 8,
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_lock,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_lock,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic [DATA_W-1:0] gray_data
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OWN_A = 2'd1;
  localparam logic [1:0] OWN_B = 2'd2;
  localparam logic [3:0] LOCK_MAX = 4'(MAX_LOCK);
  localparam int STAGES = 1;

  logic [1:0]      owner;
  logic            rr_ptr;     // 0: A wins next tie, 1: B wins next tie
  logic [3:0]      lock_cnt;
  logic [STAGES:0] vld_pipe;
  logic [STAGES:0] id_pipe;    // 0: A, 1: B
  logic            win_b, acc, cur_lock, same_owner;

  // A locked owner keeps the port unless it has used up its burst while the other side waits.
  always_comb begin
    win_b = 1'b0;
    if (owner == OWN_A && a_lock && a_req)
      win_b = b_req && (lock_cnt == LOCK_MAX);
    else if (owner == OWN_B && b_lock && b_req)
      win_b = !(a_req && (lock_cnt == LOCK_MAX));
    else if (a_req && b_req)
      win_b = rr_ptr;
    else
      win_b = b_req;
  end

  assign a_gnt      = reset && a_req && !win_b;
  assign b_gnt      = reset && b_req && win_b;
  assign acc        = a_gnt || b_gnt;
  assign cur_lock   = b_gnt ? b_lock : a_lock;
  assign same_owner = b_gnt ? (owner == OWN_B) : (owner == OWN_A);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner    <= IDLE;
      rr_ptr   <= 1'b0;
      lock_cnt <= '0;
    end else begin
      owner <= acc ? (b_gnt ? OWN_B : OWN_A) : IDLE;
      if (acc) rr_ptr <= !b_gnt;
      if (!acc || !cur_lock)      lock_cnt <= '0;
      else if (!same_owner)       lock_cnt <= 4'd1;
      else if (lock_cnt != LOCK_MAX) lock_cnt <= lock_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gray_req  <= 1'b0;
      gray_addr <= '0;
      vld_pipe  <= '0;
      id_pipe   <= '0;
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      gray_req <= acc;
      if (acc) gray_addr <= b_gnt ? b_addr : a_addr;
      vld_pipe <= {vld_pipe[STAGES-1:0], acc};
      id_pipe  <= {id_pipe[STAGES-1:0], b_gnt};
      // vld_pipe[STAGES] lines up with the cycle the memory drives gray_data.
      a_rvalid <= vld_pipe[STAGES] && !id_pipe[STAGES];
      b_rvalid <= vld_pipe[STAGES] &&  id_pipe[STAGES];
      if (vld_pipe[STAGES] && !id_pipe[STAGES]) a_rdata <= gray_data;
      if (vld_pipe[STAGES] &&  id_pipe[STAGES]) b_rdata <= gray_data;
    end
  end
endmodule

// File: tb/tb_gray_mem_arbiter.sv
// Directed bench for gray_mem_arbiter with a registered-read memory model.
module tb_gray_mem_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       a_req = 0, a_lock = 0, b_req = 0, b_lock = 0;
  logic [5:0] a_addr = '0, b_addr = '0;
  logic       a_gnt, b_gnt, a_rvalid, b_rvalid, gray_req;
  logic [7:0] a_rdata, b_rdata, gray_data;
  logic [5:0] gray_addr;
  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  gray_mem_arbiter #(.MAX_LOCK(8), .ADDR_W(6), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_lock(a_lock), .a_gnt(a_gnt),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_addr(b_addr), .b_lock(b_lock), .b_gnt(b_gnt),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data)
  );

  function automatic logic [7:0] mem_f(input logic [5:0] a);
    return ({2'b00, a} * 8'd5) + 8'h11;
  endfunction

  // memory contents are mem_f(addr); data appears the cycle after gray_req
  always_ff @(posedge clk) if (gray_req) gray_data <= mem_f(gray_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    a_req = 1; b_req = 1; reset = 0;
    #1;
    chk("rst_agnt", a_gnt, 0);     chk("rst_bgnt", b_gnt, 0);
    chk("rst_greq", gray_req, 0);  chk("rst_gaddr", gray_addr, 0);
    chk("rst_arv", a_rvalid, 0);   chk("rst_brv", b_rvalid, 0);
    chk("rst_ard", a_rdata, 0);    chk("rst_brd", b_rdata, 0);
    @(negedge clk);
    reset = 1; a_req = 0; b_req = 0; a_lock = 0; b_lock = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // single A stream, addresses 9,10,11
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      a_req = (i < 3); a_addr = 6'(9 + i);
      #1;
      chk("t1_agnt", a_gnt, i < 3);
      chk("t1_bgnt", b_gnt, 0);
      chk("t1_brv", b_rvalid, 0);
      if (i >= 1) chk("t1_greq", gray_req, i <= 3);
      if (i >= 1 && i <= 3) chk("t1_gaddr", gray_addr, 9 + i - 1);
      if (i >= 3) chk("t1_arv", a_rvalid, i <= 5);
      if (i >= 3 && i <= 5) chk("t1_ard", a_rdata, mem_f(6'(i - 3 + 9)));
    end

    // contention without lock: A,B,A,B
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a_req = (i < 4); b_req = (i < 4);
      a_addr = 6'(1 + i / 2); b_addr = 6'(33 + i / 2);
      #1;
      chk("t2_agnt", a_gnt, (i < 4) && (i % 2 == 0));
      chk("t2_bgnt", b_gnt, (i < 4) && (i % 2 == 1));
      if (i >= 1 && i <= 4)
        chk("t2_gaddr", gray_addr, ((i - 1) % 2 == 0) ? 1 + (i - 1) / 2 : 33 + (i - 1) / 2);
      if (i >= 3) begin
        chk("t2_arv", a_rvalid, (i <= 6) && ((i - 3) % 2 == 0));
        chk("t2_brv", b_rvalid, (i <= 6) && ((i - 3) % 2 == 1));
      end
      if (i >= 3 && i <= 6 && (i - 3) % 2 == 0) chk("t2_ard", a_rdata, mem_f(6'(1 + (i - 3) / 2)));
      if (i >= 3 && i <= 6 && (i - 3) % 2 == 1) chk("t2_brd", b_rdata, mem_f(6'(33 + (i - 3) / 2)));
    end

    // A locked while B waits: 8 A grants, one B, then A again
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      a_req = 1; a_lock = 1; a_addr = 6'd5;
      b_req = (i <= 8); b_addr = 6'd40;
      #1;
      chk("t3_agnt", a_gnt, i != 8);
      chk("t3_bgnt", b_gnt, i == 8);
      if (i >= 3) chk("t3_brv", b_rvalid, i == 11);
      if (i == 11) chk("t3_brd", b_rdata, mem_f(6'd40));
    end

    // A locked alone for 20 reads: no gaps
    do_reset();
    a_lock = 1;
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      a_req = (i < 20); a_addr = 6'(i);
      #1;
      chk("t4_agnt", a_gnt, i < 20);
      if (i >= 1) chk("t4_greq", gray_req, i <= 20);
      if (i >= 1 && i <= 20) chk("t4_gaddr", gray_addr, i - 1);
      if (i >= 3) chk("t4_arv", a_rvalid, i <= 22);
      if (i >= 3 && i <= 22) chk("t4_ard", a_rdata, mem_f(6'(i - 3)));
    end

    // idle gaps: requests at cycles 0 and 5 only
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      a_req = (i == 0 || i == 5);
      a_addr = (i == 0) ? 6'd12 : (i == 5) ? 6'd20 : 6'd63;
      #1;
      chk("t5_agnt", a_gnt, i == 0 || i == 5);
      if (i >= 1) begin
        chk("t5_greq", gray_req, i == 1 || i == 6);
        chk("t5_gaddr", gray_addr, (i <= 5) ? 12 : 20);
      end
      if (i >= 3) chk("t5_arv", a_rvalid, i == 3 || i == 8);
      if (i == 3) chk("t5_ard0", a_rdata, mem_f(6'd12));
      if (i == 8) chk("t5_ard1", a_rdata, mem_f(6'd20));
    end

    // async reset while a read is in flight
    @(negedge clk);
    a_req = 1; a_addr = 6'd7;
    #1;
    chk("t6_agnt", a_gnt, 1);
    @(negedge clk);
    a_req = 0;
    #1;
    chk("t6_greq", gray_req, 1);
    chk("t6_gaddr", gray_addr, 7);
    #2;
    reset = 0; a_req = 1;
    #1;
    chk("t6_rgreq", gray_req, 0);
    chk("t6_rgaddr", gray_addr, 0);
    chk("t6_ragnt", a_gnt, 0);
    @(negedge clk);
    reset = 1; a_req = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("t6_arv_drop", a_rvalid, 0);
      chk("t6_brv_drop", b_rvalid, 0);
    end
    @(negedge clk);
    a_req = 1; a_addr = 6'd3;
    #1;
    chk("t6_agnt2", a_gnt, 1);
    @(negedge clk);
    a_req = 0;
    #1;
    chk("t6_greq2", gray_req, 1);
    chk("t6_gaddr2", gray_addr, 3);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("t6_arv2", a_rvalid, 1);
    chk("t6_ard2", a_rdata, mem_f(6'd3));

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/gray_mem_arbiter.md
Name: gray_mem_arbiter

Overview:
Two-requester arbiter for the single-port 64x8 gray image memory. Requester A is the LBP engine and requester B is a secondary reader, such as a histogram engine or host readback. Each requester has its own valid/grant channel plus optional burst lock. The block drives the memory's gray_req/gray_addr/gray_data interface (1-cycle read latency) and routes each returned byte to the requester that issued it.

Parameters:
MAX_LOCK, 8, max consecutive grants one locked owner may take while the other requester is waiting (1..15)
ADDR_W, 6, memory address width
DATA_W, 8, memory data width

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
a_req  in  1  requester A read request (level; hold with a_addr until granted)
a_addr  in  ADDR_W  requester A read address
a_lock  in  1  requester A keeps ownership across consecutive requests
a_gnt  out  1  combinational; a_req && a_gnt in a cycle = request accepted
a_rvalid  out  1  a_rdata valid (1-cycle pulse per accepted read)
a_rdata  out  DATA_W  read data for A
b_req, b_addr, b_lock, b_gnt, b_rvalid, b_rdata  same as the A ports, for requester B
gray_req  out  1  memory read strobe (registered)
gray_addr  out  ADDR_W  memory address (registered)
gray_data  in  DATA_W  memory read data, valid the cycle after gray_req

Behaviour:
- Reset (reset=0, async): gray_req=0, gray_addr=0, a/b_rvalid=0, a/b_rdata=0, owner=IDLE, rr_ptr=A, lock_cnt=0, return pipe cleared. a_gnt and b_gnt are 0 while reset is asserted.
- Owner FSM states: IDLE, OWN_A, OWN_B.
  - IDLE: only one requester asserting → grant it. Both asserting → grant rr_ptr side.
  - OWN_X with x_lock=1 and x_req=1: stay OWN_X.
  - OWN_X without lock: recompute winner each cycle exactly as in IDLE.
  - No requests in a cycle → IDLE next cycle.
- Round robin: after every accepted request, rr_ptr points to the requester that was not granted.
- Lock limit: lock_cnt counts consecutive accepted grants to a locked owner. When lock_cnt==MAX_LOCK and the other requester is asserting, ownership is forced to the other side on the next arbitration and lock_cnt clears. lock_cnt also clears on any owner change or when lock drops.
- Grant: a_gnt and b_gnt are combinational from req/owner/rr_ptr/lock_cnt. They are mutually exclusive and never asserted without the matching req. At most one acceptance per cycle.
- Pipeline, for an acceptance in cycle N:
  - cycle N+1: gray_req=1, gray_addr=accepted addr.
  - cycle N+2: memory drives gray_data.
  - cycle N+3: x_rvalid=1, x_rdata=registered gray_data.
  - Read latency is therefore 3 cycles from acceptance.
- gray_req=0 in any cycle following a cycle with no acceptance. gray_addr holds its last value.
- Back-to-back throughput is 1 read/cycle. A 2-bit tag pipe (owner id + valid) travels alongside the request so returns go to the correct requester even when owners alternate every cycle.
- Return ordering equals acceptance order. rvalid has no backpressure; requesters must accept data when it arrives.
- Address is sampled only in the acceptance cycle. Changing addr while not granted is legal.
- Reset mid-operation: in-flight reads are dropped and no rvalid is produced for them.

Test Plan:
- Single A stream: a_req held, a_addr=9,10,11 advanced on each a_gnt → gray_req high for 3 consecutive cycles with gray_addr 9,10,11. a_rvalid high 3 cycles starting 3 cycles after the first accept, with matching data. b_rvalid stays 0.
- Contention, no lock: both request continuously from reset → grants alternate A,B,A,B. gray_addr interleaves accordingly. Each rdata is routed to the correct port.
- Lock with starvation limit (MAX_LOCK=8): A locks, B requests from the same cycle → exactly 8 consecutive A grants, then a B grant, then A again if A is still locked and requesting.
- Lock, no contention: A locked for 20 reads, B idle → 20 consecutive A grants with no gaps and lock_cnt saturation has no effect.
- Idle gaps: A requests at cycles 0 and 5 only → gray_req high only at cycles 1 and 6. Arbiter returns to IDLE in between and gray_addr holds its value.
- Async reset at cycle N+1 of an accepted read → all outputs go to reset values immediately, no rvalid for the dropped read, and normal operation resumes one cycle after reset deassertion.
